// File: rtl/cnn_pkg.sv
// Shared types for the CNN window generator.
// Cell widths, FSM state encoding, packed cell bundle and a masking helper.
package cnn_pkg;

    localparam int U_W = 8;
    localparam int Y_W = 9;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic        [U_W-1:0] u;
        logic signed [Y_W-1:0] y;
    } cell_t;

    // Force a cell to zero when it lies outside the frame.
    function automatic cell_t mask_cell(input cell_t c, input logic keep);
        return keep ? c : '0;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// DEPTH-cell delay line of packed cells, advanced only when en_i is high.
// Ports: clk, en_i (advance), din_i (cell in), dout_o (cell DEPTH steps old).
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  en_i,
    input  cell_t din_i,
    output cell_t dout_o
);

    // No reset: stale contents only ever reach masked window positions.
    cell_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// 3x3 zero-padded neighbourhood generator over a raster-scanned cell frame.
// Ports: in_valid/in_ready/in_u/in_y cell stream in; out_valid/out_ready,
// U1..U9, Y1..Y9, out_row/out_col (centre position), out_last window out.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [U_W-1:0]             in_u,
    input  logic signed [Y_W-1:0]      in_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [U_W-1:0]             U1,
    output logic [U_W-1:0]             U2,
    output logic [U_W-1:0]             U3,
    output logic [U_W-1:0]             U4,
    output logic [U_W-1:0]             U5,
    output logic [U_W-1:0]             U6,
    output logic [U_W-1:0]             U7,
    output logic [U_W-1:0]             U8,
    output logic [U_W-1:0]             U9,
    output logic signed [Y_W-1:0]      Y1,
    output logic signed [Y_W-1:0]      Y2,
    output logic signed [Y_W-1:0]      Y3,
    output logic signed [Y_W-1:0]      Y4,
    output logic signed [Y_W-1:0]      Y5,
    output logic signed [Y_W-1:0]      Y6,
    output logic signed [Y_W-1:0]      Y7,
    output logic signed [Y_W-1:0]      Y8,
    output logic signed [Y_W-1:0]      Y9,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       out_last
);

    localparam int N     = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(N);
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);

    localparam logic [CNT_W-1:0] FILL_END = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N - 1);
    localparam logic [RW-1:0]    ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [CW-1:0]    COL_MAX  = CW'(IMG_W - 1);

    state_e state_q, state_d;

    logic [CNT_W-1:0] in_cnt_q;
    logic [RW-1:0]    nxt_row_q;
    logic [CW-1:0]    nxt_col_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [RW-1:0]    out_row_q;
    logic [CW-1:0]    out_col_q;

    logic slot_free;
    logic in_rdy;
    logic accept;
    logic inject;
    logic produce;
    logic step;
    logic last_taken;

    cell_t cell_in;
    cell_t lb_mid;
    cell_t lb_top;
    cell_t win_q [3][3];
    cell_t win_m [9];
    logic  row_ok [3];
    logic  col_ok [3];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (accept && in_cnt_q == FILL_END) state_d = RUN;
            RUN:     if (accept && in_cnt_q == LAST_IN)  state_d = FLUSH;
            FLUSH:   if (last_taken)                     state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        slot_free  = !out_valid_q || out_ready;
        in_rdy     = (state_q != FLUSH) && slot_free;
        accept     = in_valid && in_rdy;
        // Stop injecting once the last window sits in the output register.
        inject     = (state_q == FLUSH) && slot_free
                     && !(out_valid_q && out_last_q);
        produce    = inject || (accept && state_q == RUN);
        step       = accept || inject;
        last_taken = out_valid_q && out_ready && out_last_q;
    end

    assign in_ready = in_rdy;

    // Flush pushes zero cells through the line buffers.
    always_comb begin
        cell_in = '0;
        if (state_q != FLUSH) begin
            cell_in.u = in_u;
            cell_in.y = in_y;
        end
    end

    // ---------------- counters and output control ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt_q    <= '0;
            nxt_row_q   <= '0;
            nxt_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            if (accept) begin
                in_cnt_q <= (in_cnt_q == LAST_IN) ? '0 : in_cnt_q + 1'b1;
            end
            if (produce) begin
                out_valid_q <= 1'b1;
                out_row_q   <= nxt_row_q;
                out_col_q   <= nxt_col_q;
                out_last_q  <= (nxt_row_q == ROW_MAX)
                               && (nxt_col_q == COL_MAX);
                if (nxt_col_q == COL_MAX) begin
                    nxt_col_q <= '0;
                    nxt_row_q <= (nxt_row_q == ROW_MAX) ? '0
                                 : nxt_row_q + 1'b1;
                end else begin
                    nxt_col_q <= nxt_col_q + 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // ---------------- line buffers: rows r-1 and r ----------------
    cnn_line_buffer #(
        .DEPTH (IMG_W)
    ) u_lb_mid (
        .clk    (clk),
        .en_i   (step),
        .din_i  (cell_in),
        .dout_o (lb_mid)
    );

    cnn_line_buffer #(
        .DEPTH (IMG_W)
    ) u_lb_top (
        .clk    (clk),
        .en_i   (step),
        .din_i  (lb_mid),
        .dout_o (lb_top)
    );

    // ---------------- 3x3 window shift ----------------
    // Column 2 takes the newest column; centre lands IMG_W+1 cells behind.
    always_ff @(posedge clk) begin
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb_top;
            win_q[1][2] <= lb_mid;
            win_q[2][2] <= cell_in;
        end
    end

    // ---------------- edge masking ----------------
    // Row/column wrap and stale line-buffer data only appear in the
    // positions cleared here.
    always_comb begin
        row_ok[0] = (out_row_q != '0);
        row_ok[1] = 1'b1;
        row_ok[2] = (out_row_q != ROW_MAX);
        col_ok[0] = (out_col_q != '0);
        col_ok[1] = 1'b1;
        col_ok[2] = (out_col_q != COL_MAX);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_m[r*3+c] = mask_cell(win_q[r][c],
                    out_valid_q && row_ok[r] && col_ok[c]);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

    assign U1 = win_m[0].u;
    assign U2 = win_m[1].u;
    assign U3 = win_m[2].u;
    assign U4 = win_m[3].u;
    assign U5 = win_m[4].u;
    assign U6 = win_m[5].u;
    assign U7 = win_m[6].u;
    assign U8 = win_m[7].u;
    assign U9 = win_m[8].u;

    assign Y1 = win_m[0].y;
    assign Y2 = win_m[1].y;
    assign Y3 = win_m[2].y;
    assign Y4 = win_m[3].y;
    assign Y5 = win_m[4].y;
    assign Y6 = win_m[5].y;
    assign Y7 = win_m[6].y;
    assign Y8 = win_m[7].y;
    assign Y9 = win_m[8].y;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen on a 4x3 frame.
// Cell (r,c) carries U=base+4r+c+1, Y=-U; base alternates 0/100 per frame.
module tb_cnn_window_gen;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_u;
    logic signed [8:0] in_y;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        U1, U2, U3, U4, U5, U6, U7, U8, U9;
    logic signed [8:0] Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, Y9;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;

    cnn_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_u      (in_u),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .U1 (U1), .U2 (U2), .U3 (U3), .U4 (U4), .U5 (U5),
        .U6 (U6), .U7 (U7), .U8 (U8), .U9 (U9),
        .Y1 (Y1), .Y2 (Y2), .Y3 (Y3), .Y4 (Y4), .Y5 (Y5),
        .Y6 (Y6), .Y7 (Y7), .Y8 (Y8), .Y9 (Y9),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    logic [7:0]        u_a [9];
    logic signed [8:0] y_a [9];
    logic [158:0]      all_o;

    always_comb begin
        u_a[0] = U1; u_a[1] = U2; u_a[2] = U3;
        u_a[3] = U4; u_a[4] = U5; u_a[5] = U6;
        u_a[6] = U7; u_a[7] = U8; u_a[8] = U9;
        y_a[0] = Y1; y_a[1] = Y2; y_a[2] = Y3;
        y_a[3] = Y4; y_a[4] = Y5; y_a[5] = Y6;
        y_a[6] = Y7; y_a[7] = Y8; y_a[8] = Y9;
        all_o  = {U1, U2, U3, U4, U5, U6, U7, U8, U9,
                  Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y8, Y9,
                  out_row, out_col, out_last, out_valid};
    end

    // Hand-computed windows for base-0 frames.
    int hu00 [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    int hu13 [9] = '{3, 4, 0, 7, 8, 0, 11, 12, 0};
    int hu23 [9] = '{7, 8, 0, 11, 12, 0, 0, 0, 0};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    function automatic int exp_u(input int base, input int k, input int p);
        int r;
        int c;
        r = k / W + p / 3 - 1;
        c = k % W + p % 3 - 1;
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return base + W * r + c + 1;
    endfunction

    int send_left, drv_k, drv_base, frm_acc;
    int mon_k, mon_base, mon_tot, n_last, cyc;
    int vgap, rgap, acc6_cyc, fv_cyc, diffs;
    bit force_stall, in_flush, post_last;
    logic [158:0] snap;

    task automatic check_win();
        for (int p = 0; p < 9; p++) begin
            chk($sformatf("U%0d_k%0d", p + 1, mon_k), int'(u_a[p]),
                exp_u(mon_base, mon_k, p));
            chk($sformatf("Y%0d_k%0d", p + 1, mon_k), int'(y_a[p]),
                -exp_u(mon_base, mon_k, p));
        end
        chk($sformatf("row_k%0d", mon_k), int'(out_row), mon_k / W);
        chk($sformatf("col_k%0d", mon_k), int'(out_col), mon_k % W);
        chk($sformatf("last_k%0d", mon_k), int'(out_last),
            int'(mon_k == N - 1));
        if (mon_base == 0) begin
            if (mon_k == 0) begin
                for (int p = 0; p < 9; p++)
                    chk($sformatf("h00_U%0d", p + 1), int'(u_a[p]), hu00[p]);
                chk("h00_Y5", int'(Y5), -1);
                chk("h00_Y9", int'(Y9), -6);
            end
            if (mon_k == 7) begin
                for (int p = 0; p < 9; p++)
                    chk($sformatf("h13_U%0d", p + 1), int'(u_a[p]), hu13[p]);
            end
            if (mon_k == 11) begin
                for (int p = 0; p < 9; p++)
                    chk($sformatf("h23_U%0d", p + 1), int'(u_a[p]), hu23[p]);
                chk("h23_Y4", int'(Y4), -11);
                chk("h23_last", int'(out_last), 1);
            end
        end
    endtask

    // One clock: drive at negedge, look #1 later, edge follows.
    task automatic tick();
        @(negedge clk);
        in_valid  = (send_left > 0) && ($urandom_range(99) >= vgap);
        in_u      = 8'(drv_base + drv_k + 1);
        in_y      = 9'(-(drv_base + drv_k + 1));
        out_ready = !force_stall && ($urandom_range(99) >= rgap);
        #1;
        cyc++;
        if (post_last) begin
            chk("rdy_after_last", int'(in_ready), 1);
            post_last = 1'b0;
        end
        if (in_flush) chk("flush_rdy", int'(in_ready), 0);
        if (out_valid && fv_cyc < 0) fv_cyc = cyc;
        if (in_valid && in_ready) begin
            send_left--;
            frm_acc++;
            if (frm_acc == 6 && acc6_cyc < 0) acc6_cyc = cyc;
            if (drv_k == N - 1) begin
                drv_k    = 0;
                drv_base = 100 - drv_base;
                frm_acc  = 0;
                in_flush = 1'b1;
            end else begin
                drv_k++;
            end
        end
        if (out_valid && out_ready) begin
            check_win();
            mon_tot++;
            if (out_last) begin
                n_last++;
                in_flush  = 1'b0;
                post_last = 1'b1;
            end
            if (mon_k == N - 1) begin
                mon_k    = 0;
                mon_base = 100 - mon_base;
            end else begin
                mon_k++;
            end
        end
    endtask

    task automatic run_win(input int target, input int max_cyc);
        int n;
        n = 0;
        while (mon_tot < target && n < max_cyc) begin
            tick();
            n++;
        end
        chk("win_count", mon_tot, target);
    endtask

    task automatic clear_model();
        drv_k     = 0;
        drv_base  = 0;
        frm_acc   = 0;
        mon_k     = 0;
        mon_base  = 0;
        mon_tot   = 0;
        in_flush  = 1'b0;
        post_last = 1'b0;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_u        = '0;
        in_y        = '0;
        out_ready   = 1'b1;
        force_stall = 1'b0;
        vgap        = 0;
        rgap        = 0;
        send_left   = 0;
        n_last      = 0;
        cyc         = 0;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_row", int'(out_row), 0);
        chk("rst_col", int'(out_col), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        for (int p = 0; p < 9; p++) begin
            chk($sformatf("rst_U%0d", p + 1), int'(u_a[p]), 0);
            chk($sformatf("rst_Y%0d", p + 1), int'(y_a[p]), 0);
        end
        rst_n = 1'b1;

        // Full frame, continuous traffic
        acc6_cyc  = -1;
        fv_cyc    = -1;
        send_left = N;
        run_win(N, 100);
        chk("first_valid_lat", fv_cyc - acc6_cyc, 1);
        tick();
        chk("last_cnt_f1", n_last, 1);

        // Backpressure mid-RUN
        mon_tot   = 0;
        send_left = N;
        run_win(5, 100);
        force_stall = 1'b1;
        tick();
        snap  = all_o;
        diffs = 0;
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_rdy0", int'(in_ready), 0);
        repeat (9) begin
            tick();
            if (all_o != snap) diffs++;
            chk("stall_rdy", int'(in_ready), 0);
        end
        chk("stall_stable", diffs, 0);
        force_stall = 1'b0;
        run_win(N, 200);
        tick();

        // Reset after 7 accepted cells
        send_left = N;
        n = 0;
        while (frm_acc < 7 && n < 100) begin
            tick();
            n++;
        end
        chk("acc7", frm_acc, 7);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_valid", int'(out_valid), 0);
        for (int p = 0; p < 9; p++) begin
            chk($sformatf("mrst_U%0d", p + 1), int'(u_a[p]), 0);
            chk($sformatf("mrst_Y%0d", p + 1), int'(y_a[p]), 0);
        end
        clear_model();
        send_left = N;
        run_win(N, 100);
        tick();

        // Two back-to-back frames with random gaps
        n_last    = 0;
        mon_tot   = 0;
        send_left = 2 * N;
        vgap      = 30;
        rgap      = 30;
        run_win(2 * N, 2000);
        chk("last_cnt_b2b", n_last, 2);
        vgap = 0;
        rgap = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
